// File: rtl/microprocessor_system.sv
// Multi-cycle 32-bit load/store CPU with unified internal word memory,
// an external wait-stated memory bus and an 8-bit I/O window at 0xFFFF_FFxx.
module microprocessor_system #(
   parameter int MEM_WORDS = 16384
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] ext_addr,
   inout  wire  [31:0] ext_data,
   output logic        ext_mem_read,
   output logic        ext_mem_write,
   output logic        ext_mem_enable,
   input  logic        ext_mem_ready,
   output logic [7:0]  io_addr,
   inout  wire  [7:0]  io_data,
   output logic        io_read,
   output logic        io_write,
   input  logic [7:0]  external_interrupts,
   output logic        system_halted,
   output logic [31:0] pc_out,
   output logic [7:0]  cpu_flags
);

   localparam int          IDX_W     = $clog2(MEM_WORDS);
   localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS) * 32'd4;

   localparam logic [5:0] OP_ADD  = 6'h01, OP_SUB  = 6'h02, OP_AND  = 6'h03;
   localparam logic [5:0] OP_OR   = 6'h04, OP_XOR  = 6'h05, OP_SLT  = 6'h06;
   localparam logic [5:0] OP_SLL  = 6'h07, OP_SRL  = 6'h08, OP_ADDI = 6'h10;
   localparam logic [5:0] OP_LUI  = 6'h11, OP_ORI  = 6'h12, OP_LW   = 6'h18;
   localparam logic [5:0] OP_SW   = 6'h19, OP_BEQ  = 6'h20, OP_BNE  = 6'h21;
   localparam logic [5:0] OP_BLT  = 6'h22, OP_BGE  = 6'h23, OP_JAL  = 6'h28;
   localparam logic [5:0] OP_JR   = 6'h29, OP_HALT = 6'h3F;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC  = 2'd1,
      S_MEM   = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   logic [31:0] internal_memory [MEM_WORDS];
   logic [31:0] regs_q [32];

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d, ir_q, ir_d, addr_q, addr_d, wdata_q, wdata_d;
   logic [3:0]  flags_q, flags_d;   // {V, C, N, Z}
   logic        irq_q, irq_d, halted_q, halted_d, is_load_q, is_load_d;
   logic        ext_rd_q, ext_rd_d, ext_wr_q, ext_wr_d, ext_en_q, ext_en_d;
   logic        io_rd_q, io_rd_d, io_wr_q, io_wr_d;

   logic        rf_we_s, mem_we_s, taken_s, alu_upd_s, alu_c_s, alu_v_s;
   logic [4:0]  rf_waddr_s;
   logic [31:0] rf_wdata_s, alu_res_s;
   logic [32:0] sum_s;

   function automatic logic is_int_f(input logic [31:0] a);
      return a < MEM_BYTES;
   endfunction

   function automatic logic is_io_f(input logic [31:0] a);
      return a[31:8] == 24'hFF_FFFF;
   endfunction

   wire [5:0]  op    = ir_q[31:26];
   wire [4:0]  rd    = ir_q[25:21];
   wire [4:0]  rs1   = ir_q[20:16];
   wire [4:0]  rs2   = ir_q[15:11];
   wire [15:0] imm   = ir_q[15:0];
   wire [31:0] simm  = {{16{imm[15]}}, imm};
   wire [31:0] zimm  = {16'd0, imm};
   wire [31:0] rs1v  = regs_q[rs1];
   wire [31:0] rs2v  = regs_q[rs2];
   wire [31:0] rdv   = regs_q[rd];
   wire [31:0] pc_p4 = pc_q + 32'd4;
   wire [31:0] br_tg = pc_p4 + {simm[29:0], 2'b00};
   wire [31:0] ea    = rs1v + simm;

   // ALU result and flag candidates for the instruction in ir_q
   always_comb begin
      alu_res_s = 32'd0;
      alu_c_s   = 1'b0;
      alu_v_s   = 1'b0;
      alu_upd_s = 1'b0;
      sum_s     = 33'd0;
      case (op)
         OP_ADD: begin
            sum_s     = {1'b0, rs1v} + {1'b0, rs2v};
            alu_res_s = sum_s[31:0];
            alu_c_s   = sum_s[32];
            alu_v_s   = (rs1v[31] == rs2v[31]) && (sum_s[31] != rs1v[31]);
            alu_upd_s = 1'b1;
         end
         OP_ADDI: begin
            sum_s     = {1'b0, rs1v} + {1'b0, simm};
            alu_res_s = sum_s[31:0];
            alu_c_s   = sum_s[32];
            alu_v_s   = (rs1v[31] == simm[31]) && (sum_s[31] != rs1v[31]);
            alu_upd_s = 1'b1;
         end
         OP_SUB: begin
            sum_s     = {1'b0, rs1v} - {1'b0, rs2v};
            alu_res_s = sum_s[31:0];
            alu_c_s   = sum_s[32];   // borrow
            alu_v_s   = (rs1v[31] != rs2v[31]) && (sum_s[31] != rs1v[31]);
            alu_upd_s = 1'b1;
         end
         OP_AND: begin alu_res_s = rs1v & rs2v; alu_upd_s = 1'b1; end
         OP_OR:  begin alu_res_s = rs1v | rs2v; alu_upd_s = 1'b1; end
         OP_XOR: begin alu_res_s = rs1v ^ rs2v; alu_upd_s = 1'b1; end
         OP_SLT: begin
            alu_res_s = {31'd0, ($signed(rs1v) < $signed(rs2v))};
            alu_upd_s = 1'b1;
         end
         OP_SLL: begin alu_res_s = rs1v << rs2v[4:0]; alu_upd_s = 1'b1; end
         OP_SRL: begin alu_res_s = rs1v >> rs2v[4:0]; alu_upd_s = 1'b1; end
         OP_ORI: begin alu_res_s = rs1v | zimm; alu_upd_s = 1'b1; end
         OP_LUI: alu_res_s = {imm, 16'd0};
         default: alu_res_s = 32'd0;
      endcase
   end

   // Branch condition: rd is the left-hand operand
   always_comb begin
      case (op)
         OP_BEQ:  taken_s = (rdv == rs1v);
         OP_BNE:  taken_s = (rdv != rs1v);
         OP_BLT:  taken_s = ($signed(rdv) <  $signed(rs1v));
         OP_BGE:  taken_s = ($signed(rdv) >= $signed(rs1v));
         default: taken_s = 1'b0;
      endcase
   end

   // Next-state, writeback and strobe decode
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      flags_d    = flags_q;
      halted_d   = halted_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      is_load_d  = is_load_q;
      irq_d      = |external_interrupts;
      ext_rd_d   = 1'b0;
      ext_wr_d   = 1'b0;
      ext_en_d   = 1'b0;
      io_rd_d    = 1'b0;
      io_wr_d    = 1'b0;
      rf_we_s    = 1'b0;
      rf_waddr_s = rd;
      rf_wdata_s = 32'd0;
      mem_we_s   = 1'b0;
      case (state_q)
         S_FETCH: begin
            ir_d    = internal_memory[pc_q[IDX_W+1:2]];
            state_d = S_EXEC;
         end
         S_EXEC: begin
            pc_d    = pc_p4;
            state_d = S_FETCH;
            if (alu_upd_s) begin
               flags_d = {alu_v_s, alu_c_s, alu_res_s[31], (alu_res_s == 32'd0)};
            end else begin
               flags_d = flags_q;
            end
            case (op)
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLL, OP_SRL,
               OP_ADDI, OP_LUI, OP_ORI: begin
                  rf_we_s    = 1'b1;
                  rf_wdata_s = alu_res_s;
               end
               OP_BEQ, OP_BNE, OP_BLT, OP_BGE: begin
                  if (taken_s) begin
                     pc_d = br_tg;
                  end else begin
                     pc_d = pc_p4;
                  end
               end
               OP_JAL: begin
                  rf_we_s    = 1'b1;
                  rf_wdata_s = pc_p4;
                  pc_d       = br_tg;
               end
               OP_JR: pc_d = rs1v;
               OP_LW, OP_SW: begin
                  state_d   = S_MEM;
                  addr_d    = ea;
                  wdata_d   = rdv;
                  is_load_d = (op == OP_LW);
                  if (is_int_f(ea)) begin
                     ext_en_d = 1'b0;
                  end else if (is_io_f(ea)) begin
                     io_rd_d = (op == OP_LW);
                     io_wr_d = (op == OP_SW);
                  end else begin
                     ext_en_d = 1'b1;
                     ext_rd_d = (op == OP_LW);
                     ext_wr_d = (op == OP_SW);
                  end
               end
               OP_HALT: begin
                  state_d  = S_HALT;
                  pc_d     = pc_q;
                  halted_d = 1'b1;
               end
               default: pc_d = pc_p4;
            endcase
         end
         S_MEM: begin
            rf_waddr_s = rd;
            if (is_int_f(addr_q)) begin
               state_d    = S_FETCH;
               rf_we_s    = is_load_q;
               rf_wdata_s = internal_memory[addr_q[IDX_W+1:2]];
               mem_we_s   = !is_load_q;
            end else if (is_io_f(addr_q)) begin
               state_d    = S_FETCH;
               rf_we_s    = is_load_q;
               rf_wdata_s = {24'd0, io_data};
            end else if (ext_mem_ready) begin
               state_d    = S_FETCH;
               rf_we_s    = is_load_q;
               rf_wdata_s = ext_data;
            end else begin
               state_d  = S_MEM;
               ext_en_d = 1'b1;
               ext_rd_d = is_load_q;
               ext_wr_d = !is_load_q;
            end
         end
         S_HALT: begin
            state_d  = S_HALT;
            halted_d = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Architectural state and registered strobes; reset aborts any access
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         pc_q      <= 32'd0;
         ir_q      <= 32'd0;
         flags_q   <= 4'd0;
         irq_q     <= 1'b0;
         halted_q  <= 1'b0;
         addr_q    <= 32'd0;
         wdata_q   <= 32'd0;
         is_load_q <= 1'b0;
         ext_rd_q  <= 1'b0;
         ext_wr_q  <= 1'b0;
         ext_en_q  <= 1'b0;
         io_rd_q   <= 1'b0;
         io_wr_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         flags_q   <= flags_d;
         irq_q     <= irq_d;
         halted_q  <= halted_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         is_load_q <= is_load_d;
         ext_rd_q  <= ext_rd_d;
         ext_wr_q  <= ext_wr_d;
         ext_en_q  <= ext_en_d;
         io_rd_q   <= io_rd_d;
         io_wr_q   <= io_wr_d;
      end
   end

   // Register file; r0 is never written so it stays zero
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= 32'd0;
         end
      end else if (rf_we_s && (rf_waddr_s != 5'd0)) begin
         regs_q[rf_waddr_s] <= rf_wdata_s;
      end
   end

   // Internal memory store port (contents survive reset)
   always_ff @(posedge clk) begin
      if (mem_we_s && !rst) begin
         internal_memory[addr_q[IDX_W+1:2]] <= wdata_q;
      end
   end

   assign ext_addr       = addr_q;
   assign ext_mem_read   = ext_rd_q;
   assign ext_mem_write  = ext_wr_q;
   assign ext_mem_enable = ext_en_q;
   assign ext_data       = ext_wr_q ? wdata_q : {32{1'bz}};
   assign io_addr        = addr_q[7:0];
   assign io_read        = io_rd_q;
   assign io_write       = io_wr_q;
   assign io_data        = io_wr_q ? wdata_q[7:0] : {8{1'bz}};
   assign system_halted  = halted_q;
   assign pc_out         = pc_q;
   assign cpu_flags      = {2'b00, irq_q, halted_q, flags_q};

endmodule

// File: tb/tb_microprocessor_system.sv
// Directed-program bench for microprocessor_system: reset, ALU/flags, sort,
// status word, external stall, I/O and reset during stall / after HALT.
module tb_microprocessor_system;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] ext_addr;
   wire  [31:0] ext_data;
   logic        ext_mem_read, ext_mem_write, ext_mem_enable;
   logic        ext_mem_ready = 1'b0;
   logic [7:0]  io_addr;
   wire  [7:0]  io_data;
   logic        io_read, io_write;
   logic [7:0]  external_interrupts = 8'd0;
   logic        system_halted;
   logic [31:0] pc_out;
   logic [7:0]  cpu_flags;

   logic        ext_drv = 1'b0;
   logic [31:0] ext_val = 32'd0;
   logic        io_drv  = 1'b0;
   logic [7:0]  io_val  = 8'd0;

   int n_checks = 0;
   int n_fail   = 0;

   assign ext_data = ext_drv ? ext_val : {32{1'bz}};
   assign io_data  = io_drv  ? io_val  : {8{1'bz}};
   wire [4:0] strobes = {ext_mem_read, ext_mem_write, ext_mem_enable, io_read, io_write};

   always #5 clk = ~clk;

   microprocessor_system #(.MEM_WORDS(16384)) dut (
      .clk(clk), .rst(rst),
      .ext_addr(ext_addr), .ext_data(ext_data),
      .ext_mem_read(ext_mem_read), .ext_mem_write(ext_mem_write),
      .ext_mem_enable(ext_mem_enable), .ext_mem_ready(ext_mem_ready),
      .io_addr(io_addr), .io_data(io_data), .io_read(io_read), .io_write(io_write),
      .external_interrupts(external_interrupts), .system_halted(system_halted),
      .pc_out(pc_out), .cpu_flags(cpu_flags)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ei(input logic [5:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [15:0] imm);
      return {op, rd, rs1, imm};
   endfunction

   function automatic logic [31:0] er(input logic [5:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2);
      return {op, rd, rs1, rs2, 11'd0};
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 16384; i++) dut.internal_memory[i] = 32'd0;
   endtask

   task automatic wait_halt(input int budget);
      for (int i = 0; i < budget && !system_halted; i++) step(1);
   endtask

   task automatic load_ext_prog();
      clear_mem();
      dut.internal_memory[0] = ei(6'h11, 5'd1, 5'd0, 16'h0010);  // LUI r1,0x0010
      dut.internal_memory[1] = ei(6'h18, 5'd2, 5'd1, 16'h0000);  // LW r2,0(r1)
      dut.internal_memory[2] = ei(6'h19, 5'd2, 5'd1, 16'h0000);  // SW r2,0(r1)
      dut.internal_memory[3] = ei(6'h10, 5'd3, 5'd0, 16'hFF10);  // ADDI r3,r0,-240
      dut.internal_memory[4] = ei(6'h18, 5'd4, 5'd3, 16'h0000);  // LW r4,0(r3)
      dut.internal_memory[5] = ei(6'h19, 5'd2, 5'd3, 16'h0000);  // SW r2,0(r3)
      dut.internal_memory[6] = 32'hFC00_0000;                     // HALT
   endtask

   initial begin
      // Reset values and NOP stepping
      rst = 1'b1;
      step(1);
      clear_mem();
      step(1);
      check_eq("rst_pc", pc_out, 32'd0);
      check_eq("rst_halted", {31'd0, system_halted}, 32'd0);
      check_eq("rst_flags", {24'd0, cpu_flags}, 32'd0);
      check_eq("rst_strobes", {27'd0, strobes}, 32'd0);
      rst = 1'b0;
      step(2);
      check_eq("nop_pc4", pc_out, 32'd4);
      step(3);
      check_eq("nop_pc_hold", pc_out, 32'd8);
      step(1);
      check_eq("nop_pc12", pc_out, 32'd12);

      // ALU and flags
      rst = 1'b1;
      step(1);
      clear_mem();
      dut.internal_memory[0] = ei(6'h10, 5'd1, 5'd0, 16'hFFFF);  // ADDI r1,r0,-1
      dut.internal_memory[1] = ei(6'h10, 5'd2, 5'd1, 16'h0001);  // ADDI r2,r1,1
      dut.internal_memory[2] = ei(6'h11, 5'd3, 5'd0, 16'h7FFF);  // LUI r3,0x7FFF
      dut.internal_memory[3] = ei(6'h12, 5'd3, 5'd3, 16'hFFFF);  // ORI r3,r3,0xFFFF
      dut.internal_memory[4] = ei(6'h10, 5'd3, 5'd3, 16'h0001);  // ADDI r3,r3,1
      dut.internal_memory[5] = er(6'h02, 5'd4, 5'd2, 5'd1);      // SUB r4,r2,r1
      dut.internal_memory[6] = er(6'h08, 5'd5, 5'd1, 5'd4);      // SRL r5,r1,r4
      dut.internal_memory[7] = er(6'h06, 5'd6, 5'd1, 5'd4);      // SLT r6,r1,r4
      dut.internal_memory[8] = 32'hFC00_0000;                     // HALT
      step(1);
      rst = 1'b0;
      step(4);
      check_eq("addi_r2", dut.regs_q[2], 32'd0);
      check_eq("addi_flags_zc", {24'd0, cpu_flags}, 32'h05);
      step(2);
      check_eq("lui_r3", dut.regs_q[3], 32'h7FFF_0000);
      check_eq("lui_keeps_flags", {24'd0, cpu_flags}, 32'h05);
      step(2);
      check_eq("ori_r3", dut.regs_q[3], 32'h7FFF_FFFF);
      check_eq("ori_flags", {24'd0, cpu_flags}, 32'h00);
      step(2);
      check_eq("ovf_r3", dut.regs_q[3], 32'h8000_0000);
      check_eq("ovf_flags_vn", {24'd0, cpu_flags}, 32'h0A);
      step(2);
      check_eq("sub_r4", dut.regs_q[4], 32'd1);
      check_eq("sub_flags_borrow", {24'd0, cpu_flags}, 32'h04);
      step(2);
      check_eq("srl_r5", dut.regs_q[5], 32'h7FFF_FFFF);
      step(2);
      check_eq("slt_r6", dut.regs_q[6], 32'd1);
      check_eq("slt_flags", {24'd0, cpu_flags}, 32'h00);
      step(1);
      check_eq("halt_not_yet", {31'd0, system_halted}, 32'd0);
      step(1);
      check_eq("halt_flags", {24'd0, cpu_flags}, 32'h10);
      check_eq("halt_pc", pc_out, 32'h20);
      external_interrupts = 8'h04;
      step(1);
      check_eq("irq_flag", {24'd0, cpu_flags}, 32'h30);
      step(2);
      check_eq("halt_pc_frozen", pc_out, 32'h20);
      external_interrupts = 8'h00;
      step(1);
      check_eq("irq_clear", {24'd0, cpu_flags}, 32'h10);

      // Bubble sort of four words at 0x1000
      rst = 1'b1;
      step(1);
      clear_mem();
      dut.internal_memory[0]  = ei(6'h10, 5'd1, 5'd0, 16'd3);      // ADDI r1,r0,3
      dut.internal_memory[1]  = ei(6'h10, 5'd2, 5'd0, 16'h1000);   // ADDI r2,r0,0x1000
      dut.internal_memory[2]  = ei(6'h10, 5'd3, 5'd0, 16'd3);      // ADDI r3,r0,3
      dut.internal_memory[3]  = ei(6'h18, 5'd4, 5'd2, 16'd0);      // LW r4,0(r2)
      dut.internal_memory[4]  = ei(6'h18, 5'd5, 5'd2, 16'd4);      // LW r5,4(r2)
      dut.internal_memory[5]  = ei(6'h23, 5'd5, 5'd4, 16'd2);      // BGE r5,r4,+2
      dut.internal_memory[6]  = ei(6'h19, 5'd5, 5'd2, 16'd0);      // SW r5,0(r2)
      dut.internal_memory[7]  = ei(6'h19, 5'd4, 5'd2, 16'd4);      // SW r4,4(r2)
      dut.internal_memory[8]  = ei(6'h10, 5'd2, 5'd2, 16'd4);      // ADDI r2,r2,4
      dut.internal_memory[9]  = ei(6'h10, 5'd3, 5'd3, 16'hFFFF);   // ADDI r3,r3,-1
      dut.internal_memory[10] = ei(6'h21, 5'd3, 5'd0, 16'hFFF8);   // BNE r3,r0,-8
      dut.internal_memory[11] = ei(6'h10, 5'd1, 5'd1, 16'hFFFF);   // ADDI r1,r1,-1
      dut.internal_memory[12] = ei(6'h21, 5'd1, 5'd0, 16'hFFF4);   // BNE r1,r0,-12
      dut.internal_memory[13] = 32'hFC00_0000;                      // HALT
      dut.internal_memory[32'h400] = 32'd80000;
      dut.internal_memory[32'h401] = 32'd10000;
      dut.internal_memory[32'h402] = 32'd50000;
      dut.internal_memory[32'h403] = 32'd30000;
      step(1);
      rst = 1'b0;
      wait_halt(10000);
      check_eq("sort_halted", {31'd0, system_halted}, 32'd1);
      check_eq("sort_w0", dut.internal_memory[32'h400], 32'd10000);
      check_eq("sort_w1", dut.internal_memory[32'h401], 32'd30000);
      check_eq("sort_w2", dut.internal_memory[32'h402], 32'd50000);
      check_eq("sort_w3", dut.internal_memory[32'h403], 32'd80000);

      // Status word at 0x2000
      rst = 1'b1;
      step(1);
      clear_mem();
      dut.internal_memory[0] = ei(6'h10, 5'd1, 5'd0, 16'd1);       // ADDI r1,r0,1
      dut.internal_memory[1] = ei(6'h19, 5'd1, 5'd0, 16'h2000);    // SW r1,0x2000(r0)
      dut.internal_memory[2] = 32'hFC00_0000;                       // HALT
      step(1);
      rst = 1'b0;
      step(4);
      check_eq("status_before_mem", dut.internal_memory[32'h800], 32'd0);
      check_eq("status_no_ext", {27'd0, strobes}, 32'd0);
      step(1);
      check_eq("status_after_mem", dut.internal_memory[32'h800], 32'd1);
      step(1);
      check_eq("status_halt_c6", {31'd0, system_halted}, 32'd0);
      step(1);
      check_eq("status_halt_c7", {31'd0, system_halted}, 32'd1);

      // External stall, external store, I/O load/store
      rst = 1'b1;
      step(1);
      load_ext_prog();
      step(1);
      rst = 1'b0;
      step(4);
      check_eq("ext_rd_c1", {27'd0, strobes}, 32'b10100);
      check_eq("ext_addr", ext_addr, 32'h0010_0000);
      check_eq("ext_pc", pc_out, 32'd8);
      ext_drv = 1'b1;
      ext_val = 32'hCAFE_1234;
      step(1);
      check_eq("ext_rd_c2", {27'd0, strobes}, 32'b10100);
      step(1);
      check_eq("ext_rd_c3", {27'd0, strobes}, 32'b10100);
      step(1);
      check_eq("ext_rd_c4", {27'd0, strobes}, 32'b10100);
      check_eq("ext_addr_held", ext_addr, 32'h0010_0000);
      ext_mem_ready = 1'b1;
      step(1);
      ext_mem_ready = 1'b0;
      ext_drv = 1'b0;
      check_eq("ext_rd_done", {27'd0, strobes}, 32'd0);
      step(2);
      check_eq("ext_wr_strobe", {27'd0, strobes}, 32'b01100);
      check_eq("ext_wr_data", ext_data, 32'hCAFE_1234);
      ext_mem_ready = 1'b1;
      step(1);
      ext_mem_ready = 1'b0;
      check_eq("ext_wr_done", {27'd0, strobes}, 32'd0);
      step(4);
      check_eq("io_rd_strobe", {27'd0, strobes}, 32'b00010);
      check_eq("io_addr", {24'd0, io_addr}, 32'h10);
      io_drv = 1'b1;
      io_val = 8'hA5;
      step(1);
      io_drv = 1'b0;
      check_eq("io_rd_done", {27'd0, strobes}, 32'd0);
      check_eq("io_rd_r4", dut.regs_q[4], 32'h0000_00A5);
      step(2);
      check_eq("io_wr_strobe", {27'd0, strobes}, 32'b00001);
      check_eq("io_wr_data", {24'd0, io_data}, 32'h34);
      step(1);
      check_eq("io_wr_done", {27'd0, strobes}, 32'd0);
      step(2);
      check_eq("ext_prog_halted", {31'd0, system_halted}, 32'd1);

      // Reset during an external stall, then after HALT
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      step(5);
      check_eq("stall_before_rst", {27'd0, strobes}, 32'b10100);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      check_eq("rst_stall_strobes", {27'd0, strobes}, 32'd0);
      check_eq("rst_stall_pc", pc_out, 32'd0);
      step(4);
      check_eq("rerun_ext_rd", {27'd0, strobes}, 32'b10100);
      check_eq("rerun_pc", pc_out, 32'd8);
      ext_drv = 1'b1;
      ext_val = 32'h1111_2222;
      ext_mem_ready = 1'b1;
      step(1);
      ext_mem_ready = 1'b0;
      ext_drv = 1'b0;
      step(2);
      check_eq("rerun_wr_data", ext_data, 32'h1111_2222);
      ext_mem_ready = 1'b1;
      step(1);
      ext_mem_ready = 1'b0;
      wait_halt(60);
      check_eq("rerun_halted", {31'd0, system_halted}, 32'd1);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      check_eq("rst_halt_halted", {31'd0, system_halted}, 32'd0);
      check_eq("rst_halt_pc", pc_out, 32'd0);
      check_eq("rst_halt_flags", {24'd0, cpu_flags}, 32'd0);
      step(2);
      check_eq("rst_halt_restart", pc_out, 32'd4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
